// File: rtl/bus_pkg.sv
// Shared definitions for the write-back byte demultiplexer: default sizes,
// channel index assignments and common data types.
package bus_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;
    localparam int unsigned NCH_DEFAULT   = 4;
    localparam int unsigned CNT_W_DEFAULT = 8;
    localparam int unsigned SEL_W         = 2;

    typedef logic [7:0]       byte_t;
    typedef logic [SEL_W-1:0] sel_t;

    // Destination assignment on the write-back path
    localparam sel_t CH_REG_A = 2'd0;
    localparam sel_t CH_REG_B = 2'd1;
    localparam sel_t CH_OUT   = 2'd2;
    localparam sel_t CH_MEM   = 2'd3;

endpackage

// File: rtl/demux_slot.sv
// One output channel of the demultiplexer: a single-entry holding register
// with valid/ready drain and a wrapping count of delivered bytes.
module demux_slot
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [WIDTH-1:0] data_q,  data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             xfer;

    assign xfer = valid_q & ready_i;

    // Load wins over drain so a same-cycle drain+reload keeps valid high;
    // data is kept after a drain so the slice shows the last byte delivered.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q & ~ready_i;
        cnt_d   = cnt_q;
        if (xfer) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (load_i) begin
            data_d  = din_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/bus_demux1to4.sv
// One-to-four buffered demultiplexer: steers a producer byte into one of four
// per-channel holding registers, each drained independently via valid/ready.
module bus_demux1to4
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned NCH   = NCH_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   din,
    input  logic               din_valid,
    input  logic [SEL_W-1:0]   din_select,
    output logic               din_ready,
    output logic [NCH*WIDTH-1:0] dout,
    output logic [NCH-1:0]     dout_valid,
    input  logic [NCH-1:0]     dout_ready,
    output logic [NCH*CNT_W-1:0] deliver_cnt
);

    logic [NCH-1:0] slot_valid;
    logic [NCH-1:0] slot_load;
    logic           accept;

    // Ready depends only on the selected channel; din_valid never feeds it,
    // and an X select while din_valid=0 is masked out of every load enable.
    assign din_ready = rst_n & (~slot_valid[din_select] | dout_ready[din_select]);
    assign accept    = din_valid & din_ready;

    always_comb begin
        slot_load = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            slot_load[k] = accept & (din_select == sel_t'(k));
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (slot_load[k]),
            .din_i   (din),
            .ready_i (dout_ready[k]),
            .data_o  (dout[k*WIDTH +: WIDTH]),
            .valid_o (slot_valid[k]),
            .cnt_o   (deliver_cnt[k*CNT_W +: CNT_W])
        );
    end

    assign dout_valid = slot_valid;

endmodule

// File: tb/tb_bus_demux1to4.sv
// Self-checking bench for bus_demux1to4: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_bus_demux1to4;
    import bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    byte_t       din;
    logic        din_valid;
    sel_t        din_select;
    logic        din_ready;
    logic [31:0] dout;
    logic [3:0]  dout_valid;
    logic [3:0]  dout_ready;
    logic [31:0] deliver_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_demux1to4 #(
        .WIDTH (8),
        .NCH   (4),
        .CNT_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .din_select  (din_select),
        .din_ready   (din_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .deliver_cnt (deliver_cnt)
    );

    typedef struct {
        logic        rst_n;
        byte_t       din;
        logic        v;
        sel_t        sel;
        logic [3:0]  rdy;
        logic        exp_ready;
        logic [3:0]  exp_valid;
        logic [31:0] exp_dout;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vt[10];

    // Reference model: each channel is a queue of pending bytes plus the
    // byte currently shown on its slice and a delivered count modulo 256.
    byte_t pend[4][$];
    byte_t shown[4];
    int    mcnt[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input byte_t d, input logic v, input sel_t s,
                         input logic [3:0] rd);
        rst_n      = r;
        din        = d;
        din_valid  = v;
        din_select = s;
        dout_ready = rd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        for (int k = 0; k < 4; k++) begin
            pend[k].delete();
            shown[k] = 8'h00;
            mcnt[k]  = 0;
        end
    endtask

    initial begin
        // Basic routing followed by backpressure on channel 1
        vt[0] = '{1'b1, 8'hA5, 1'b1, CH_OUT,   4'hF, 1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000};
        vt[1] = '{1'b1, 8'h00, 1'b0, CH_REG_A, 4'hF, 1'b1, 4'b0100, 32'h00A5_0000, 32'h0000_0000};
        vt[2] = '{1'b1, 8'h00, 1'b0, CH_REG_A, 4'hF, 1'b1, 4'b0000, 32'h00A5_0000, 32'h0001_0000};
        vt[3] = '{1'b1, 8'h11, 1'b1, CH_REG_B, 4'hD, 1'b1, 4'b0000, 32'h00A5_0000, 32'h0001_0000};
        vt[4] = '{1'b1, 8'h22, 1'b1, CH_REG_B, 4'hD, 1'b0, 4'b0010, 32'h00A5_1100, 32'h0001_0000};
        vt[5] = '{1'b1, 8'h33, 1'b1, CH_MEM,   4'hD, 1'b1, 4'b0010, 32'h00A5_1100, 32'h0001_0000};
        vt[6] = '{1'b1, 8'h22, 1'b1, CH_REG_B, 4'hD, 1'b0, 4'b1010, 32'h33A5_1100, 32'h0001_0000};
        vt[7] = '{1'b1, 8'h22, 1'b1, CH_REG_B, 4'hF, 1'b1, 4'b0010, 32'h33A5_1100, 32'h0101_0000};
        vt[8] = '{1'b1, 8'h00, 1'b0, CH_REG_A, 4'hF, 1'b1, 4'b0010, 32'h33A5_2200, 32'h0101_0100};
        vt[9] = '{1'b1, 8'h00, 1'b0, CH_REG_A, 4'hF, 1'b1, 4'b0000, 32'h33A5_2200, 32'h0101_0200};

        // Reset held two cycles with a pending producer byte
        drive(1'b0, 8'hFF, 1'b1, CH_OUT, 4'hF);
        #4;
        check("rst_ready_early", din_ready, 1'b0);
        tick;
        tick;
        #4;
        check("rst_ready", din_ready, 1'b0);
        check("rst_dout", dout, 32'h0);
        check("rst_valid", dout_valid, 4'h0);
        check("rst_cnt", deliver_cnt, 32'h0);
        tick;

        for (int i = 0; i < 10; i++) begin
            drive(vt[i].rst_n, vt[i].din, vt[i].v, vt[i].sel, vt[i].rdy);
            #4;
            check($sformatf("vec%0d_ready", i), din_ready, vt[i].exp_ready);
            check($sformatf("vec%0d_valid", i), dout_valid, vt[i].exp_valid);
            check($sformatf("vec%0d_dout", i), dout, vt[i].exp_dout);
            check($sformatf("vec%0d_cnt", i), deliver_cnt, vt[i].exp_cnt);
            tick;
        end

        // Streaming 0x00..0x07 into channel 0
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, byte_t'(i), 1'b1, CH_REG_A, 4'hF);
            #4;
            check("stream_ready", din_ready, 1'b1);
            check("stream_valid0", dout_valid[0], i > 0);
            if (i > 0) check("stream_data0", dout[7:0], byte_t'(i - 1));
            tick;
        end
        drive(1'b1, 8'h00, 1'b0, CH_REG_A, 4'hF);
        #4;
        check("stream_last_valid", dout_valid, 4'b0001);
        check("stream_last_data", dout[7:0], 8'h07);
        tick;
        #4;
        check("stream_idle_valid", dout_valid, 4'b0000);
        check("stream_cnt0", deliver_cnt[7:0], 8'd8);
        tick;

        // Reset while channels 0 and 2 hold stalled bytes
        drive(1'b1, 8'hC1, 1'b1, CH_REG_A, 4'h0);
        tick;
        drive(1'b1, 8'hC2, 1'b1, CH_OUT, 4'h0);
        #4;
        check("midrst_pre_valid", dout_valid, 4'b0001);
        tick;
        drive(1'b0, 8'hEE, 1'b1, CH_MEM, 4'h0);
        #4;
        check("midrst_held_valid", dout_valid, 4'b0101);
        check("midrst_ready", din_ready, 1'b0);
        tick;
        drive(1'b1, 8'h00, 1'b0, CH_REG_A, 4'hF);
        #4;
        check("midrst_valid", dout_valid, 4'b0000);
        check("midrst_dout", dout, 32'h0);
        check("midrst_cnt", deliver_cnt, 32'h0);
        tick;
        #4;
        check("midrst_no_drain_cnt", deliver_cnt, 32'h0);
        check("midrst_no_drain_valid", dout_valid, 4'b0000);
        tick;

        // 256 transfers on channel 3: counter wraps back to zero
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, byte_t'(i), 1'b1, CH_MEM, 4'hF);
            tick;
        end
        drive(1'b1, 8'h00, 1'b0, CH_REG_A, 4'hF);
        #4;
        check("wrap_cnt3_255", deliver_cnt[31:24], 8'd255);
        check("wrap_valid", dout_valid, 4'b1000);
        check("wrap_data3", dout[31:24], 8'hFF);
        tick;
        #4;
        check("wrap_cnt3_0", deliver_cnt[31:24], 8'd0);
        check("wrap_idle", dout_valid, 4'b0000);
        tick;

        // Randomized traffic against the queue model
        drive(1'b0, 8'h00, 1'b0, CH_REG_A, 4'h0);
        tick;
        model_clear();
        for (int c = 0; c < 400; c++) begin
            logic        r, v, exp_ready;
            byte_t       d;
            sel_t        s;
            logic [3:0]  rd, exp_valid;
            logic [31:0] exp_dout, exp_cnt;
            r  = ($urandom % 40) != 0;
            d  = byte_t'($urandom);
            v  = ($urandom % 4) != 0;
            s  = sel_t'($urandom);
            rd = 4'($urandom);
            drive(r, d, v, s, rd);
            #4;
            exp_ready = r && (pend[s].size() == 0 || rd[s]);
            for (int k = 0; k < 4; k++) begin
                exp_valid[k]      = pend[k].size() != 0;
                exp_dout[k*8 +: 8] = shown[k];
                exp_cnt[k*8 +: 8]  = 8'(mcnt[k]);
            end
            check("rand_ready", din_ready, exp_ready);
            check("rand_valid", dout_valid, exp_valid);
            check("rand_dout", dout, exp_dout);
            check("rand_cnt", deliver_cnt, exp_cnt);
            if (!r) begin
                model_clear();
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (pend[k].size() != 0 && rd[k]) begin
                        void'(pend[k].pop_front());
                        mcnt[k] = (mcnt[k] + 1) % 256;
                    end
                end
                if (v && exp_ready) begin
                    pend[s].push_back(d);
                    shown[s] = d;
                end
            end
            tick;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
